// File: rtl/mem_stage_pkg.sv
// Shared bus widths and field layouts for the execute/memory/write-back interfaces.
// Execute, write-back and decode import the same definitions.
package mycpu_defs;

    localparam int EX_MEM_W  = 71;
    localparam int MEM_WB_W  = 70;
    localparam int MEM_FWD_W = 39;

    localparam int EXM_PC_LSB       = 39;
    localparam int EXM_GR_WE        = 38;
    localparam int EXM_DEST_LSB     = 33;
    localparam int EXM_ALU_LSB      = 1;
    localparam int EXM_RES_FROM_MEM = 0;

    localparam int MWB_PC_LSB   = 38;
    localparam int MWB_GR_WE    = 37;
    localparam int MWB_DEST_LSB = 32;
    localparam int MWB_RES_LSB  = 0;

    localparam int FWD_LOAD_PENDING = 38;
    localparam int FWD_WE           = 37;
    localparam int FWD_DEST_LSB     = 32;
    localparam int FWD_RES_LSB      = 0;

    // Struct member order reproduces the bit offsets above, MSB first.
    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic        res_from_mem;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] pc;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } mem_wb_t;

    typedef struct packed {
        logic        load_pending;
        logic        fwd_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
    } mem_fwd_t;

endpackage

// File: rtl/mem_stage_rdata_buf.sv
// One-entry holding register for load data that arrives while write-back stalls.
module mem_rdata_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] din,
    output logic        valid,
    output logic [31:0] dout
);

    logic        valid_q, valid_d;
    logic [31:0] data_q, data_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (capture) begin
            valid_d = 1'b1;
            data_d  = din;
        end
        if (clear) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign dout  = data_q;

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: latches execute payload, waits for load data,
// and buffers it while write-back stalls.
module mem_stage
    import mycpu_defs::*;
(
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 WB_allow_in,
    input  logic                 EX_to_MEM_valid,
    input  logic [EX_MEM_W-1:0]  EX_MEM_reg,
    input  logic                 data_sram_data_ok,
    input  logic [31:0]          data_sram_rdata,
    output logic                 MEM_allow_in,
    output logic                 MEM_to_WB_valid,
    output logic [MEM_WB_W-1:0]  MEM_WB_reg,
    output logic [MEM_FWD_W-1:0] MEM_fwd
);

    logic        mem_valid_q, mem_valid_d;
    ex_mem_t     payload_q, payload_d;

    logic        buf_valid;
    logic [31:0] buf_data;
    logic        buf_capture;
    logic        buf_clear;

    logic        data_ok_acc;
    logic        ready_go;
    logic        load_en;
    logic        leave;
    logic [31:0] final_result;
    mem_wb_t     wb_bus;
    mem_fwd_t    fwd_bus;

    always_comb begin
        // Only a resident load with an empty buffer may consume data_ok.
        data_ok_acc     = mem_valid_q && payload_q.res_from_mem && !buf_valid
                          && data_sram_data_ok;
        ready_go        = !payload_q.res_from_mem || buf_valid || data_ok_acc;
        MEM_allow_in    = !mem_valid_q || (ready_go && WB_allow_in);
        MEM_to_WB_valid = mem_valid_q && ready_go;
        load_en         = EX_to_MEM_valid && MEM_allow_in;
        leave           = MEM_to_WB_valid && WB_allow_in;

        buf_capture = data_ok_acc && !WB_allow_in;
        buf_clear   = leave || load_en;

        mem_valid_d = MEM_allow_in ? EX_to_MEM_valid : mem_valid_q;
        payload_d   = load_en ? ex_mem_t'(EX_MEM_reg) : payload_q;

        if (!payload_q.res_from_mem) begin
            final_result = payload_q.alu_result;
        end else if (buf_valid) begin
            final_result = buf_data;
        end else begin
            final_result = data_sram_rdata;
        end

        wb_bus.pc           = payload_q.pc;
        wb_bus.gr_we        = payload_q.gr_we;
        wb_bus.dest         = payload_q.dest;
        wb_bus.final_result = final_result;

        fwd_bus.load_pending = mem_valid_q && payload_q.res_from_mem && !ready_go;
        fwd_bus.fwd_we       = mem_valid_q && payload_q.gr_we && ready_go;
        fwd_bus.dest         = payload_q.dest;
        fwd_bus.final_result = final_result;

        MEM_WB_reg = wb_bus;
        MEM_fwd    = fwd_bus;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_valid_q <= 1'b0;
            payload_q   <= '0;
        end else begin
            mem_valid_q <= mem_valid_d;
            payload_q   <= payload_d;
        end
    end

    mem_rdata_buf u_rdata_buf (
        .clk     (clk),
        .resetn  (resetn),
        .capture (buf_capture),
        .clear   (buf_clear),
        .din     (data_sram_rdata),
        .valid   (buf_valid),
        .dout    (buf_data)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios then randomized traffic
// against an instruction-level reference model.
module tb_mem_stage;

    logic        clk;
    logic        resetn;
    logic        WB_allow_in;
    logic        EX_to_MEM_valid;
    logic [70:0] EX_MEM_reg;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        MEM_allow_in;
    logic        MEM_to_WB_valid;
    logic [69:0] MEM_WB_reg;
    logic [38:0] MEM_fwd;

    int checks;
    int failures;

    mem_stage dut (
        .clk               (clk),
        .resetn            (resetn),
        .WB_allow_in       (WB_allow_in),
        .EX_to_MEM_valid   (EX_to_MEM_valid),
        .EX_MEM_reg        (EX_MEM_reg),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .MEM_allow_in      (MEM_allow_in),
        .MEM_to_WB_valid   (MEM_to_WB_valid),
        .MEM_WB_reg        (MEM_WB_reg),
        .MEM_fwd           (MEM_fwd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  dest;
        logic [31:0] alu;
        logic        load;
    } inst_t;

    // Reference model: the instruction currently held and whether its load data has been seen.
    bit          m_res;
    inst_t       m_inst;
    bit          m_seen;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_ex(input logic v, input logic [31:0] pc, input logic we,
                            input logic [4:0] dest, input logic [31:0] alu, input logic ld);
        EX_to_MEM_valid = v;
        EX_MEM_reg      = {pc, we, dest, alu, ld};
    endtask

    task automatic chk_wb(input string tag, input logic [31:0] pc, input logic we,
                          input logic [4:0] dest, input logic [31:0] res);
        chk({tag, "_valid"}, 70'(MEM_to_WB_valid), 70'(1'b1));
        chk({tag, "_pc"}, 70'(MEM_WB_reg[69:38]), 70'(pc));
        chk({tag, "_we"}, 70'(MEM_WB_reg[37]), 70'(we));
        chk({tag, "_dest"}, 70'(MEM_WB_reg[36:32]), 70'(dest));
        chk({tag, "_res"}, 70'(MEM_WB_reg[31:0]), 70'(res));
    endtask

    initial begin
        logic [31:0] r1, r2, r3;
        bit          exp_ready, exp_valid, exp_allow;
        logic [31:0] exp_res;
        inst_t       nxt;

        checks   = 0;
        failures = 0;
        resetn            = 1'b0;
        WB_allow_in       = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0;
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_allow", 70'(MEM_allow_in), 70'(1'b1));
        chk("rst_valid", 70'(MEM_to_WB_valid), 70'(1'b0));
        chk("rst_wb", 70'(MEM_WB_reg), 70'(0));
        chk("rst_fwd", 70'(MEM_fwd), 70'(0));
        resetn = 1'b1;
        tick();

        // ALU op
        drive_ex(1'b1, 32'h1C00_0000, 1'b1, 5'd5, 32'h1234, 1'b0);
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk_wb("alu", 32'h1C00_0000, 1'b1, 5'd5, 32'h1234);
        chk("alu_fwd_we", 70'(MEM_fwd[37]), 70'(1'b1));
        chk("alu_fwd_pend", 70'(MEM_fwd[38]), 70'(1'b0));
        tick();
        chk("alu_gone", 70'(MEM_to_WB_valid), 70'(1'b0));

        // Load with data_ok low for two cycles
        data_sram_data_ok = 1'b0;
        drive_ex(1'b1, 32'h1C00_0010, 1'b1, 5'd3, 32'h8000_0000, 1'b1);
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("ldw_pend", 70'(MEM_fwd[38]), 70'(1'b1));
            chk("ldw_allow", 70'(MEM_allow_in), 70'(1'b0));
            chk("ldw_valid", 70'(MEM_to_WB_valid), 70'(1'b0));
            chk("ldw_fwd_we", 70'(MEM_fwd[37]), 70'(1'b0));
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hCAFE_0001;
        @(negedge clk);
        chk_wb("ldw", 32'h1C00_0010, 1'b1, 5'd3, 32'hCAFE_0001);
        chk("ldw_pend_done", 70'(MEM_fwd[38]), 70'(1'b0));
        chk("ldw_fwd_res", 70'(MEM_fwd[31:0]), 70'(32'hCAFE_0001));
        tick();

        // Load buffered across a three-cycle write-back stall
        WB_allow_in     = 1'b0;
        data_sram_rdata = 32'h55AA_55AA;
        drive_ex(1'b1, 32'h1C00_0020, 1'b1, 5'd7, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk_wb("buf0", 32'h1C00_0020, 1'b1, 5'd7, 32'h55AA_55AA);
        chk("buf0_allow", 70'(MEM_allow_in), 70'(1'b0));
        for (int c = 0; c < 3; c++) begin
            tick();
            data_sram_rdata   = $urandom() | 32'h1;
            data_sram_data_ok = 1'($urandom_range(0, 1));
            @(negedge clk);
            chk_wb("buf_hold", 32'h1C00_0020, 1'b1, 5'd7, 32'h55AA_55AA);
            chk("buf_hold_allow", 70'(MEM_allow_in), 70'(1'b0));
        end
        tick();
        WB_allow_in = 1'b1;
        @(negedge clk);
        chk_wb("buf_rel", 32'h1C00_0020, 1'b1, 5'd7, 32'h55AA_55AA);
        chk("buf_rel_allow", 70'(MEM_allow_in), 70'(1'b1));
        tick();
        chk("buf_gone", 70'(MEM_to_WB_valid), 70'(1'b0));

        // Stream load, ALU, load without bubbles
        data_sram_data_ok = 1'b1;
        r1 = 32'hA000_0001; r2 = 32'hB000_0002; r3 = 32'hC000_0003;
        drive_ex(1'b1, 32'h1C00_0100, 1'b1, 5'd1, 32'h0, 1'b1);
        tick();
        drive_ex(1'b1, 32'h1C00_0104, 1'b1, 5'd2, 32'h0000_BEEF, 1'b0);
        data_sram_rdata = r1;
        @(negedge clk);
        chk_wb("str_ld1", 32'h1C00_0100, 1'b1, 5'd1, r1);
        chk("str_ld1_allow", 70'(MEM_allow_in), 70'(1'b1));
        tick();
        drive_ex(1'b1, 32'h1C00_0108, 1'b0, 5'd4, 32'h0, 1'b1);
        data_sram_rdata = r2;
        @(negedge clk);
        chk_wb("str_alu", 32'h1C00_0104, 1'b1, 5'd2, 32'h0000_BEEF);
        chk("str_alu_allow", 70'(MEM_allow_in), 70'(1'b1));
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        data_sram_rdata = r3;
        @(negedge clk);
        chk_wb("str_ld2", 32'h1C00_0108, 1'b0, 5'd4, r3);
        chk("str_ld2_fwd_we", 70'(MEM_fwd[37]), 70'(1'b0));
        tick();

        // data_ok pulses around a resident non-load under a write-back stall
        WB_allow_in = 1'b0;
        drive_ex(1'b1, 32'h1C00_0200, 1'b1, 5'd9, 32'h0000_ABCD, 1'b0);
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        data_sram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk_wb("nl_dok", 32'h1C00_0200, 1'b1, 5'd9, 32'h0000_ABCD);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1111_2222;
        WB_allow_in       = 1'b1;
        @(negedge clk);
        chk_wb("nl_rel", 32'h1C00_0200, 1'b1, 5'd9, 32'h0000_ABCD);
        tick();

        // Reset mid-cycle while a load waits
        data_sram_data_ok = 1'b0;
        drive_ex(1'b1, 32'h1C00_0300, 1'b1, 5'd6, 32'h0, 1'b1);
        tick();
        drive_ex(1'b0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        @(negedge clk);
        chk("pre_rst_pend", 70'(MEM_fwd[38]), 70'(1'b1));
        resetn = 1'b0;
        #1;
        chk("mrst_valid", 70'(MEM_to_WB_valid), 70'(1'b0));
        chk("mrst_allow", 70'(MEM_allow_in), 70'(1'b1));
        chk("mrst_fwd", 70'(MEM_fwd), 70'(0));
        chk("mrst_wb", 70'(MEM_WB_reg), 70'(0));
        tick();
        resetn            = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hDEAD_BEEF;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            chk("post_rst_valid", 70'(MEM_to_WB_valid), 70'(1'b0));
            tick();
        end

        // Randomized traffic against the instruction-level model
        m_res  = 1'b0;
        m_seen = 1'b0;
        m_data = '0;
        m_inst = '{pc: '0, we: 1'b0, dest: '0, alu: '0, load: 1'b0};
        for (int i = 0; i < 500; i++) begin
            nxt.pc   = $urandom();
            nxt.we   = 1'($urandom_range(0, 1));
            nxt.dest = 5'($urandom_range(0, 31));
            nxt.alu  = $urandom();
            nxt.load = 1'($urandom_range(0, 1));
            drive_ex(1'($urandom_range(0, 1)), nxt.pc, nxt.we, nxt.dest, nxt.alu, nxt.load);
            WB_allow_in       = ($urandom_range(0, 9) < 7);
            data_sram_data_ok = ($urandom_range(0, 9) < 6);
            data_sram_rdata   = $urandom();
            @(negedge clk);

            exp_ready = !m_inst.load || m_seen || data_sram_data_ok;
            exp_valid = m_res && exp_ready;
            exp_allow = !m_res || (exp_ready && WB_allow_in);
            exp_res   = !m_inst.load ? m_inst.alu : (m_seen ? m_data : data_sram_rdata);
            chk("rnd_valid", 70'(MEM_to_WB_valid), 70'(exp_valid));
            chk("rnd_allow", 70'(MEM_allow_in), 70'(exp_allow));
            chk("rnd_pend", 70'(MEM_fwd[38]), 70'(m_res && m_inst.load && !exp_ready));
            chk("rnd_fwd_we", 70'(MEM_fwd[37]), 70'(m_res && m_inst.we && exp_ready));
            if (m_res) begin
                chk("rnd_wb", 70'(MEM_WB_reg), {m_inst.pc, m_inst.we, m_inst.dest, exp_res});
                chk("rnd_fwd_res", 70'(MEM_fwd[31:0]), 70'(exp_res));
            end

            if (m_res && m_inst.load && !m_seen && data_sram_data_ok) begin
                m_seen = 1'b1;
                m_data = data_sram_rdata;
            end
            if (exp_allow) begin
                m_res  = EX_to_MEM_valid;
                m_inst = nxt;
                m_seen = 1'b0;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage between the execute stage and the write-back stage. It latches the 71-bit execute-to-memory bus under the valid/allow_in handshake and, for loads, waits for the data SRAM response. The response is held in a one-entry buffer whenever write-back stalls. It drives the 70-bit memory-to-write-back bus and a 39-bit forwarding bus that decode uses for bypass and load-use interlock.

## Interface
- Parameters: none. All widths are fixed by the shared package.
- clk  in  1  pipeline clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- WB_allow_in  in  1  write-back can accept an instruction this cycle.
- EX_to_MEM_valid  in  1  execute presents a valid instruction.
- EX_MEM_reg  in  71  fields:
  - pc[70:39]
  - gr_we[38]
  - dest[37:33]
  - alu_result[32:1]
  - res_from_mem[0]
- data_sram_data_ok  in  1  load data valid on data_sram_rdata this cycle. Tied to 1 for a fixed one-cycle synchronous SRAM.
- data_sram_rdata  in  32  load data.
- MEM_allow_in  out  1  stage can accept from execute.
- MEM_to_WB_valid  out  1  stage presents a valid instruction to write-back.
- MEM_WB_reg  out  70  fields:
  - pc[69:38]
  - gr_we[37]
  - dest[36:32]
  - final_result[31:0]
- MEM_fwd  out  39  fields:
  - load_pending[38]
  - fwd_we[37]
  - dest[36:32]
  - final_result[31:0]

## Operation
- State:
  - MEM_valid
  - payload registers: pc, gr_we, dest, alu_result, res_from_mem
  - buf_valid, buf_data[31:0]
- Load: on EX_to_MEM_valid && MEM_allow_in, latch the whole EX_MEM_reg and clear buf_valid.
- Valid update: when MEM_allow_in is high, MEM_valid <= EX_to_MEM_valid.
- data_ok accepted: data_ok_acc = MEM_valid && res_from_mem && !buf_valid && data_sram_data_ok. It is ignored in every other case, including non-load instructions and an already-full buffer.
- MEM_ready_go = !res_from_mem || buf_valid || data_ok_acc.
- MEM_allow_in = !MEM_valid || (MEM_ready_go && WB_allow_in).
- MEM_to_WB_valid = MEM_valid && MEM_ready_go.
- Buffer capture: when data_ok_acc && !WB_allow_in, set buf_valid and capture buf_data <= data_sram_rdata.
- Buffer clear: buf_valid clears when the instruction leaves (MEM_to_WB_valid && WB_allow_in) or when a new instruction loads.
- final_result, in priority order:
  - res_from_mem=0: alu_result.
  - buf_valid: buf_data.
  - otherwise: data_sram_rdata.
- MEM_fwd:
  - load_pending = MEM_valid && res_from_mem && !MEM_ready_go.
  - fwd_we = MEM_valid && gr_we && MEM_ready_go.
  - dest and final_result pass through as registered/selected above.
- Two-state view of a load:
  - WAIT: res_from_mem && !buf_valid && !data_ok_acc.
  - HAVE: buf_valid, or data_ok_acc this cycle.
  - WAIT→HAVE on data_ok.
  - HAVE→empty or next instruction on the WB handshake.

## Timing
- Reset (asynchronous, resetn=0): all registers clear to 0.
  - Outputs while in reset: MEM_allow_in=1, MEM_to_WB_valid=0, MEM_fwd=0, MEM_WB_reg=0.
- Reset mid-load discards the in-flight instruction and any buffered data. A data_ok arriving after reset is ignored, because MEM_valid=0.
- Latency:
  - Non-load: resident one cycle when write-back is ready.
  - Load with data_ok=1: resident one cycle.
  - Each cycle data_ok is low adds one stall cycle.
- Back-to-back:
  - Departure and arrival in the same cycle is legal. The new payload is latched and buf_valid is cleared.
  - data_ok is never attributed to an instruction that has not yet been latched into this stage.
- Write-back stall while holding buffered data: MEM_WB_reg stays stable, and data_sram_rdata changes have no effect.
- Sequential elements are flip-flops only; all outputs are combinational from those registers and the inputs listed above.

## Structure
- Shared package mycpu_defs holds:
  - EX_MEM_W=71, MEM_WB_W=70, MEM_FWD_W=39
  - the field offsets above
- Execute, write-back and decode import the same constants.
- One sub-module, mem_rdata_buf: the one-entry holding register.
  - Ports: clk, resetn, capture, clear, din[31:0], valid, dout[31:0].

## Test plan
- Reset asserted mid-cycle while a load waits → MEM_to_WB_valid=0 and MEM_allow_in=1 immediately. A later data_ok with rdata=0xDEAD_BEEF produces no WB transfer.
- ALU op: pc=0x1C00_0000, dest=5, gr_we=1, alu_result=0x1234, WB_allow_in=1 → next cycle MEM_WB_reg={0x1C00_0000,1,5,0x1234} and MEM_fwd.fwd_we=1.
- Load with data_ok low for 2 cycles, then rdata=0xCAFE_0001 → load_pending=1 for 2 cycles, MEM_allow_in=0, then final_result=0xCAFE_0001 with MEM_to_WB_valid=1.
- Load: data_ok=1 with rdata=0x55AA_55AA while WB_allow_in=0 for 3 cycles, rdata changing to garbage → buffered value 0x55AA_55AA delivered when WB_allow_in rises.
- Stream load, ALU, load with data_ok=1 and WB_allow_in=1 → one instruction per cycle, no bubbles, buf_valid never set.
- data_ok pulses while a non-load resides → ignored; final_result=alu_result.
